seq_addsub_unit: RTL and testbench

- Parametrised, multi-cycle signed/unsigned adder-subtractor. It is the next generation of the team's 64-bit ripple-carry subtractor.
- Computes A+B or A−B one CHUNK-bit slice per clock. A registered carry links the slices.
- Accepts operands on a valid/ready handshake and returns result and flags on a valid/ready handshake.
- Sits as a shared arithmetic unit behind the datapath controller.

---
 rtl/seq_addsub_unit.sv | 172 +++++++++++++++++
 tb/tb_seq_addsub_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_unit.sv
// -----------------------------------------------------------------------------
// seq_addsub_unit
//
// Multi-cycle two's-complement adder/subtractor. One CHUNK-bit slice of
// A+B (or A-B) is produced per clock. A registered carry links consecutive
// slices. Operands arrive on a valid/ready handshake. Result and flags
// leave on a second valid/ready handshake.
//
// Parameters
//   WIDTH  operand/result width in bits (multiple of CHUNK)
//   CHUNK  bits processed per clock (1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   unit idle and able to accept a request
//   A, B       operands, two's complement
//   mode       0 = A+B, 1 = A-B
//   out_valid  result and flags valid
//   out_ready  consumer accepts the result
//   result     sum/difference modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       result == 0
// -----------------------------------------------------------------------------
module seq_addsub_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the counter at least one bit wide so the CHUNK == WIDTH build is legal.
  localparam int CNT_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] bx_q,     bx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;

  // Slice datapath
  int unsigned      slice_shift;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK:0]   slice_sum;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic             msb_cin;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Shift-based slice selection keeps every select in range for any WIDTH/CHUNK.
  always_comb begin
    slice_shift = 32'(cnt_q) * 32'(CHUNK);
    slice_a     = CHUNK'(a_q  >> slice_shift);
    slice_b     = CHUNK'(bx_q >> slice_shift);
    slice_sum   = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
    slice_s     = slice_sum[CHUNK-1:0];
    slice_c     = slice_sum[CHUNK];
    // Carry into the top bit of this slice is recovered from the sum bit:
    // s = a ^ b ^ cin  =>  cin = s ^ a ^ b.
    msb_cin     = slice_s[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    bx_d     = bx_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B once here and seed the carry.
          a_d     = A;
          bx_d    = mode ? ~B : B;
          carry_d = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        result_d = (result_q & ~(SLICE_MASK << slice_shift))
                 | (WIDTH'(slice_s) << slice_shift);
        carry_d  = slice_c;
        if (cnt_q == LAST_SLICE) begin
          cnt_d   = '0;
          cout_d  = slice_c;
          ovf_d   = msb_cin ^ slice_c;
          zero_d  = (result_d == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Result and flags hold until the consumer takes them.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      bx_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_addsub_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_addsub_unit
//
// Directed bench for seq_addsub_unit. Three builds share the operand bus:
//   index 0: WIDTH=64, CHUNK=16 (main)
//   index 1: WIDTH=64, CHUNK=64 (single-cycle)
//   index 2: WIDTH=64, CHUNK=1  (bit-serial)
// Each build has its own in_valid/out_ready so only one is ever addressed.
// -----------------------------------------------------------------------------
module tb_seq_addsub_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         mode_in;
  logic [2:0]   iv;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   ordy;
  logic [W-1:0] res [3];
  logic [2:0]   co;
  logic [2:0]   of;
  logic [2:0]   zr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_addsub_unit #(.WIDTH(64), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a_in), .B(b_in), .mode(mode_in), .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res[0]), .cout(co[0]), .ovf(of[0]), .zero(zr[0])
  );

  seq_addsub_unit #(.WIDTH(64), .CHUNK(64)) u_c64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a_in), .B(b_in), .mode(mode_in), .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res[1]), .cout(co[1]), .ovf(of[1]), .zero(zr[1])
  );

  seq_addsub_unit #(.WIDTH(64), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(a_in), .B(b_in), .mode(mode_in), .out_valid(ov[2]), .out_ready(ordy[2]),
    .result(res[2]), .cout(co[2]), .ovf(of[2]), .zero(zr[2])
  );

  // Present one request for one edge, then count edges until out_valid.
  // lat is the number of edges after the accepting edge (bounded).
  task automatic issue_and_wait(input int sel, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic m,
                                output int lat);
    @(negedge clk);
    a_in    = a;
    b_in    = b;
    mode_in = m;
    iv[sel] = 1'b1;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
    lat = 0;
    while (ov[sel] !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result(input int sel);
    @(negedge clk);
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", ir[0]); end
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", ov[0]); end
    checks++; if (res[0] !== 64'h0) begin errors++; $display("FAIL reset result: got %h want 0", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {co[0], of[0], zr[0]}); end
  endtask

  task automatic test_sub_negative;
    int lat;
    issue_and_wait(0, 64'd65000, 64'd65340, 1'b1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_neg latency: got %0d want 4", lat); end
    checks++; if (res[0] !== 64'hFFFF_FFFF_FFFF_FEAC) begin errors++; $display("FAIL sub_neg result: got %h want fffffffffffffeac", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b000) begin errors++; $display("FAIL sub_neg flags: got %b want 000", {co[0], of[0], zr[0]}); end
    checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL sub_neg in_ready in DONE: got %b want 0", ir[0]); end
    release_result(0);
    checks++; if ({ov[0], ir[0]} !== 2'b01) begin errors++; $display("FAIL sub_neg handoff: got ov/ir %b want 01", {ov[0], ir[0]}); end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue_and_wait(0, 64'd58135, 64'd3592, 1'b1, lat);
    checks++; if (res[0] !== 64'd54543) begin errors++; $display("FAIL b2b sub result: got %0d want 54543", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b100) begin errors++; $display("FAIL b2b sub flags: got %b want 100", {co[0], of[0], zr[0]}); end
    release_result(0);
    issue_and_wait(0, 64'd1005, 64'd69, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b add latency: got %0d want 4", lat); end
    checks++; if (res[0] !== 64'd1074) begin errors++; $display("FAIL b2b add result: got %0d want 1074", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b000) begin errors++; $display("FAIL b2b add flags: got %b want 000", {co[0], of[0], zr[0]}); end
    release_result(0);
  endtask

  task automatic test_overflow;
    int lat;
    issue_and_wait(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    checks++; if (res[0] !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf add result: got %h want 8000000000000000", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b010) begin errors++; $display("FAIL ovf add flags: got %b want 010", {co[0], of[0], zr[0]}); end
    release_result(0);
    issue_and_wait(0, 64'd0, 64'h8000_0000_0000_0000, 1'b1, lat);
    checks++; if (res[0] !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf sub result: got %h want 8000000000000000", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b010) begin errors++; $display("FAIL ovf sub flags: got %b want 010", {co[0], of[0], zr[0]}); end
    release_result(0);
  endtask

  task automatic test_backpressure;
    int lat;
    issue_and_wait(0, 64'd15124, 64'd15124, 1'b1, lat);
    checks++; if (res[0] !== 64'h0) begin errors++; $display("FAIL bp result: got %h want 0", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b101) begin errors++; $display("FAIL bp flags: got %b want 101", {co[0], of[0], zr[0]}); end
    // Disturb the operand bus while the result is held.
    @(negedge clk);
    a_in    = 64'h1234_5678_9ABC_DEF0;
    b_in    = 64'h0FED_CBA9_8765_4321;
    mode_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if ({ov[0], ir[0], zr[0]} !== 3'b101 || res[0] !== 64'h0) begin
        errors++; $display("FAIL bp hold cycle %0d: got ov/ir/zero %b result %h want 101 result 0", i, {ov[0], ir[0], zr[0]}, res[0]);
      end
    end
    release_result(0);
    checks++; if ({ov[0], ir[0]} !== 2'b01) begin errors++; $display("FAIL bp release: got ov/ir %b want 01", {ov[0], ir[0]}); end
    checks++; if (res[0] !== 64'h0 || zr[0] !== 1'b1) begin errors++; $display("FAIL bp outputs after release: got result %h zero %b want 0/1", res[0], zr[0]); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    a_in    = 64'd50;
    b_in    = 64'd10024;
    mode_in = 1'b1;
    iv[0]   = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    // Two slices are now written, so the partial result is non-zero.
    checks++; if (res[0][15:0] !== 16'hD90A) begin errors++; $display("FAIL rst_mid partial slice: got %h want d90a", res[0][15:0]); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ov[0], ir[0]} !== 2'b01) begin errors++; $display("FAIL rst_mid async state: got ov/ir %b want 01", {ov[0], ir[0]}); end
    checks++; if (res[0] !== 64'h0 || {co[0], of[0], zr[0]} !== 3'b000) begin errors++; $display("FAIL rst_mid async outputs: got result %h flags %b want 0/000", res[0], {co[0], of[0], zr[0]}); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid cycle %0d: got %b want 0", i, ov[0]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue_and_wait(0, 64'd50, 64'd10024, 1'b1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rst_mid retry latency: got %0d want 4", lat); end
    checks++; if (res[0] !== 64'hFFFF_FFFF_FFFF_D90A) begin errors++; $display("FAIL rst_mid retry result: got %h want ffffffffffffd90a", res[0]); end
    checks++; if ({co[0], of[0], zr[0]} !== 3'b000) begin errors++; $display("FAIL rst_mid retry flags: got %b want 000", {co[0], of[0], zr[0]}); end
    release_result(0);
  endtask

  task automatic test_chunk_full;
    int lat;
    issue_and_wait(1, 64'd65000, 64'd65340, 1'b1, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL c64 latency: got %0d want 1", lat); end
    checks++; if (res[1] !== 64'hFFFF_FFFF_FFFF_FEAC || co[1] !== 1'b0) begin errors++; $display("FAIL c64 sub: got result %h cout %b want fffffffffffffeac/0", res[1], co[1]); end
    release_result(1);
    issue_and_wait(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL c64 add latency: got %0d want 1", lat); end
    checks++; if (res[1] !== 64'h8000_0000_0000_0000 || {co[1], of[1], zr[1]} !== 3'b010) begin errors++; $display("FAIL c64 ovf: got result %h flags %b want 8000000000000000/010", res[1], {co[1], of[1], zr[1]}); end
    release_result(1);
  endtask

  task automatic test_chunk_bit;
    int lat;
    issue_and_wait(2, 64'd65000, 64'd65340, 1'b1, lat);
    checks++; if (lat !== 64) begin errors++; $display("FAIL c1 latency: got %0d want 64", lat); end
    checks++; if (res[2] !== 64'hFFFF_FFFF_FFFF_FEAC) begin errors++; $display("FAIL c1 result: got %h want fffffffffffffeac", res[2]); end
    checks++; if ({co[2], of[2], zr[2]} !== 3'b000) begin errors++; $display("FAIL c1 flags: got %b want 000", {co[2], of[2], zr[2]}); end
    release_result(2);
    checks++; if ({ov[2], ir[2]} !== 2'b01) begin errors++; $display("FAIL c1 handoff: got ov/ir %b want 01", {ov[2], ir[2]}); end
  endtask

  initial begin
    rst_n   = 1'b0;
    iv      = 3'b000;
    ordy    = 3'b000;
    a_in    = '0;
    b_in    = '0;
    mode_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_sub_negative;
    test_back_to_back;
    test_overflow;
    test_backpressure;
    test_reset_mid;
    test_chunk_full;
    test_chunk_bit;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
